// File: rtl/p_uart_frame_parse_pkg.sv
// Shared constants, state encodings and byte helper for the UART packet parser slice.
package p_uart_frame_parse_pkg;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
   localparam int         MAX_LEN_DEF   = 12;

   localparam logic [1:0] ERR_SYNC = 2'b01;
   localparam logic [1:0] ERR_LEN  = 2'b10;
   localparam logic [1:0] ERR_CSUM = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CHECK  = 2'd1,
      ST_STREAM = 2'd2
   } state_t;

   // Byte k of a packet; byte 0 sits in the low bits.
   function automatic logic [7:0] pkt_byte(input logic [127:0] pkt, input logic [3:0] k);
      return pkt[{k, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/p_frame_chk.sv
// Combinational framing checker: sync byte, length bound and 8-bit wrapping checksum.
module p_frame_chk
   import p_uart_frame_parse_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
   parameter int         MAX_LEN   = MAX_LEN_DEF
) (
   input  logic [127:0] pkt,
   output logic         sync_ok,
   output logic         len_ok,
   output logic         csum_ok
);

   logic [7:0] sum;

   always_comb begin
      sum = 8'd0;
      for (int k = 0; k < 15; k++) begin
         sum = sum + pkt[8*k +: 8];
      end
   end

   assign sync_ok = (pkt[7:0] == SYNC_BYTE);
   assign len_ok  = (pkt[23:16] <= 8'(MAX_LEN));
   assign csum_ok = (sum == pkt[127:120]);

endmodule

// File: rtl/p_uart_frame_parse.sv
// UART packet framing parser with one-packet skid slot and payload byte stream.
// Optional statistics counters are enabled by defining P_UART_FRAME_STATS_EN.
module p_uart_frame_parse
   import p_uart_frame_parse_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
   parameter int         MAX_LEN   = MAX_LEN_DEF
) (
   input  logic         sys_clk,
   input  logic         sys_rst_n,
   input  logic [127:0] frame_in,
   input  logic         frame_valid,
   output logic [7:0]   cmd_out,
   output logic         cmd_valid,
   output logic [7:0]   m_data,
   output logic         m_valid,
   input  logic         m_ready,
   output logic         m_last,
   output logic         frame_err,
   output logic [1:0]   err_code,
   output logic         busy,
`ifdef P_UART_FRAME_STATS_EN
   output logic [15:0]  good_cnt,
   output logic [15:0]  bad_cnt,
`endif
   output logic         overrun
);

   state_t       state, state_nxt;
   logic [127:0] work_pkt;
   logic [127:0] skid_pkt;
   logic         skid_full;
   logic [3:0]   idx;
   logic [7:0]   work_len;
   logic         sync_ok, len_ok, csum_ok;
   logic         pkt_bad;
   logic [1:0]   err_sel;
   logic         load_from_skid, load_from_in;
   logic         skid_store, overrun_nxt;

   p_frame_chk #(
      .SYNC_BYTE (SYNC_BYTE),
      .MAX_LEN   (MAX_LEN)
   ) u_chk (
      .pkt     (work_pkt),
      .sync_ok (sync_ok),
      .len_ok  (len_ok),
      .csum_ok (csum_ok)
   );

   assign work_len = work_pkt[23:16];
   assign pkt_bad  = !(sync_ok && len_ok && csum_ok);
   assign err_sel  = !sync_ok ? ERR_SYNC : (!len_ok ? ERR_LEN : ERR_CSUM);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= ST_IDLE;
      else            state <= state_nxt;
   end

   // A waiting skid packet always wins over a fresh arrival when IDLE picks up work.
   always_comb begin
      state_nxt      = state;
      load_from_skid = 1'b0;
      load_from_in   = 1'b0;
      m_valid        = 1'b0;
      m_data         = 8'd0;
      m_last         = 1'b0;
      case (state)
         ST_IDLE: begin
            if (skid_full) begin
               load_from_skid = 1'b1;
               state_nxt      = ST_CHECK;
            end else if (frame_valid) begin
               load_from_in = 1'b1;
               state_nxt    = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (pkt_bad || work_len == 8'd0) state_nxt = ST_IDLE;
            else                             state_nxt = ST_STREAM;
         end
         ST_STREAM: begin
            m_valid = 1'b1;
            m_data  = pkt_byte(work_pkt, 4'd3 + idx);
            m_last  = ({4'd0, idx} == work_len - 8'd1);
            if (m_ready && m_last) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // The skid slot can refill in the same cycle that IDLE drains it.
   assign skid_store  = frame_valid && !load_from_in && (!skid_full || load_from_skid);
   assign overrun_nxt = frame_valid && !load_from_in && skid_full && !load_from_skid;
   assign busy        = (state != ST_IDLE) || skid_full;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         work_pkt  <= '0;
         skid_pkt  <= '0;
         skid_full <= 1'b0;
         idx       <= 4'd0;
         cmd_out   <= 8'd0;
         cmd_valid <= 1'b0;
         frame_err <= 1'b0;
         err_code  <= 2'b00;
         overrun   <= 1'b0;
      end else begin
         cmd_valid <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= overrun_nxt;
         if (load_from_skid)    work_pkt <= skid_pkt;
         else if (load_from_in) work_pkt <= frame_in;
         if (skid_store) begin
            skid_pkt  <= frame_in;
            skid_full <= 1'b1;
         end else if (load_from_skid) begin
            skid_full <= 1'b0;
         end
         if (state == ST_CHECK) begin
            idx <= 4'd0;
            if (pkt_bad) begin
               frame_err <= 1'b1;
               err_code  <= err_sel;
            end else begin
               cmd_valid <= 1'b1;
               cmd_out   <= work_pkt[15:8];
            end
         end else if (m_valid && m_ready) begin
            idx <= idx + 4'd1;
         end
      end
   end

`ifdef P_UART_FRAME_STATS_EN
   logic [1:0]  bad_inc;
   logic [16:0] bad_sum;

   assign bad_inc = {1'b0, frame_err} + {1'b0, overrun};
   assign bad_sum = {1'b0, bad_cnt} + {15'd0, bad_inc};

   // Both counters saturate rather than wrap.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         good_cnt <= 16'd0;
         bad_cnt  <= 16'd0;
      end else begin
         if (cmd_valid && good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
         bad_cnt <= bad_sum[16] ? 16'hFFFF : bad_sum[15:0];
      end
   end
`endif

endmodule

// File: tb/tb_p_uart_frame_parse.sv
// Scoreboard bench for p_uart_frame_parse: directed packets, monitor pops expected outputs.
module tb_p_uart_frame_parse;

   logic         sys_clk;
   logic         sys_rst_n;
   logic [127:0] frame_in;
   logic         frame_valid;
   logic [7:0]   cmd_out;
   logic         cmd_valid;
   logic [7:0]   m_data;
   logic         m_valid;
   logic         m_ready;
   logic         m_last;
   logic         frame_err;
   logic [1:0]   err_code;
   logic         busy;
   logic         overrun;
`ifdef P_UART_FRAME_STATS_EN
   logic [15:0]  good_cnt;
   logic [15:0]  bad_cnt;
`endif

   logic [23:0]  out_vec;
   logic [7:0]   exp_cmd[$];
   logic [1:0]   exp_err[$];
   logic [8:0]   exp_beat[$];
   int           check_cnt = 0;
   int           pass_cnt  = 0;
   int           ovr_seen  = 0;

   p_uart_frame_parse dut (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .frame_in    (frame_in),
      .frame_valid (frame_valid),
      .cmd_out     (cmd_out),
      .cmd_valid   (cmd_valid),
      .m_data      (m_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_last      (m_last),
      .frame_err   (frame_err),
      .err_code    (err_code),
      .busy        (busy),
`ifdef P_UART_FRAME_STATS_EN
      .good_cnt    (good_cnt),
      .bad_cnt     (bad_cnt),
`endif
      .overrun     (overrun)
   );

   assign out_vec = {cmd_out, cmd_valid, m_data, m_valid, m_last, frame_err, err_code, busy, overrun};

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_cnt++;
      if (act === exp) pass_cnt++;
      else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #2;
   endtask

   function automatic logic [127:0] mk_pkt(input logic [7:0] sync, input logic [7:0] cmd,
                                           input logic [7:0] len, input logic [7:0] base,
                                           input logic [7:0] csum_delta);
      logic [127:0] p;
      logic [7:0]   s;
      p = '0;
      p[7:0]   = sync;
      p[15:8]  = cmd;
      p[23:16] = len;
      for (int k = 3; k < 15; k++) p[8*k +: 8] = base + 8'(17 * (k - 2));
      s = 8'd0;
      for (int k = 0; k < 15; k++) s = s + p[8*k +: 8];
      p[127:120] = s + csum_delta;
      return p;
   endfunction

   task automatic pushBeats(input logic [7:0] base, input int len);
      for (int i = 0; i < len; i++) exp_beat.push_back({(i == len - 1), base + 8'(17 * (i + 1))});
   endtask

   task automatic applyStimulus(input logic [127:0] pkt);
      tick();
      frame_in    = pkt;
      frame_valid = 1'b1;
      tick();
      frame_valid = 1'b0;
   endtask

   task automatic waitIdle(input string name);
      int n;
      n = 0;
      while ((busy || exp_cmd.size() != 0 || exp_err.size() != 0 || exp_beat.size() != 0) && n < 300) begin
         tick();
         n++;
      end
      tick();
      checkOutput({name, "_drain_timeout"}, 32'(n >= 300), 32'd0);
   endtask

   // Monitor: every DUT output event must match the head of its expectation queue.
   always @(negedge sys_clk) begin
      if (sys_rst_n) begin
         if (cmd_valid) begin
            if (exp_cmd.size() == 0) checkOutput("unexpected_cmd", 32'(cmd_out), 32'hFFFF);
            else checkOutput("cmd_out", 32'(cmd_out), 32'(exp_cmd.pop_front()));
         end
         if (frame_err) begin
            if (exp_err.size() == 0) checkOutput("unexpected_err", 32'(err_code), 32'hFFFF);
            else checkOutput("err_code", 32'(err_code), 32'(exp_err.pop_front()));
         end
         if (m_valid && m_ready) begin
            if (exp_beat.size() == 0) checkOutput("unexpected_beat", 32'({m_last, m_data}), 32'hFFFF);
            else checkOutput("beat", 32'({m_last, m_data}), 32'(exp_beat.pop_front()));
         end
         if (overrun) ovr_seen++;
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int activity;
      sys_rst_n   = 1'b0;
      frame_valid = 1'b0;
      frame_in    = '0;
      m_ready     = 1'b1;
      #1;
      checkOutput("reset_outputs", 32'(out_vec), 32'd0);
      repeat (3) tick();
      sys_rst_n = 1'b1;
      tick();
      checkOutput("post_reset_idle", 32'(out_vec), 32'd0);

      // Good packet, 3 payload bytes, consumer always ready.
      exp_cmd.push_back(8'h01);
      exp_beat.push_back({1'b0, 8'h11});
      exp_beat.push_back({1'b0, 8'h22});
      exp_beat.push_back({1'b1, 8'h33});
      applyStimulus(mk_pkt(8'hA5, 8'h01, 8'h03, 8'h00, 8'h00));
      tick();
      checkOutput("good_cmd_valid_T2", 32'(cmd_valid), 32'd1);
      checkOutput("good_m_valid_T2", 32'(m_valid), 32'd1);
      waitIdle("good");

      // Framing errors, including priority of sync over checksum.
      exp_err.push_back(2'b01);
      applyStimulus(mk_pkt(8'h5A, 8'h02, 8'h03, 8'h00, 8'h00));
      tick();
      checkOutput("sync_err_T2", 32'({frame_err, cmd_valid}), 32'b10);
      waitIdle("sync");
      exp_err.push_back(2'b10);
      applyStimulus(mk_pkt(8'hA5, 8'h03, 8'h0D, 8'h00, 8'h00));
      waitIdle("len");
      exp_err.push_back(2'b11);
      applyStimulus(mk_pkt(8'hA5, 8'h04, 8'h02, 8'h00, 8'h01));
      waitIdle("csum");
      exp_err.push_back(2'b01);
      applyStimulus(mk_pkt(8'h5A, 8'h05, 8'h02, 8'h00, 8'h01));
      waitIdle("sync_csum");

      // Maximum legal length streams all twelve bytes.
      exp_cmd.push_back(8'h06);
      pushBeats(8'h20, 12);
      applyStimulus(mk_pkt(8'hA5, 8'h06, 8'h0C, 8'h20, 8'h00));
      waitIdle("maxlen");

      // Zero-length packet: command only, no payload, idle by T+3.
      exp_cmd.push_back(8'h07);
      applyStimulus(mk_pkt(8'hA5, 8'h07, 8'h00, 8'h00, 8'h00));
      tick();
      checkOutput("len0_cmd_valid_T2", 32'(cmd_valid), 32'd1);
      tick();
      checkOutput("len0_busy_T3", 32'(busy), 32'd0);
      waitIdle("len0");

      // Stalled stream: second packet goes to skid, third overruns.
      m_ready = 1'b0;
      exp_cmd.push_back(8'h10);
      pushBeats(8'h40, 4);
      exp_cmd.push_back(8'h20);
      pushBeats(8'h80, 2);
      applyStimulus(mk_pkt(8'hA5, 8'h10, 8'h04, 8'h40, 8'h00));
      applyStimulus(mk_pkt(8'hA5, 8'h20, 8'h02, 8'h80, 8'h00));
      applyStimulus(mk_pkt(8'hA5, 8'h30, 8'h01, 8'hC0, 8'h00));
      checkOutput("stall_hold_a", 32'({m_valid, m_last, m_data}), 32'h251);
      tick();
      tick();
      checkOutput("stall_hold_b", 32'({m_valid, m_last, m_data}), 32'h251);
      checkOutput("stall_busy", 32'(busy), 32'd1);
      m_ready = 1'b1;
      waitIdle("skid");
      checkOutput("overrun_pulses", 32'(ovr_seen), 32'd1);
`ifdef P_UART_FRAME_STATS_EN
      checkOutput("good_cnt", 32'(good_cnt), 32'd5);
      checkOutput("bad_cnt", 32'(bad_cnt), 32'd5);
`endif

      // Reset in the middle of a stalled stream with the skid slot full.
      m_ready = 1'b0;
      exp_cmd.push_back(8'h50);
      applyStimulus(mk_pkt(8'hA5, 8'h50, 8'h03, 8'h10, 8'h00));
      applyStimulus(mk_pkt(8'hA5, 8'h60, 8'h02, 8'h30, 8'h00));
      checkOutput("pre_reset_busy", 32'({m_valid, busy}), 32'b11);
      #3;
      sys_rst_n = 1'b0;
      #1;
      checkOutput("midstream_reset_outputs", 32'(out_vec), 32'd0);
`ifdef P_UART_FRAME_STATS_EN
      checkOutput("reset_counters", 32'({good_cnt, bad_cnt}), 32'd0);
`endif
      exp_cmd.delete();
      exp_err.delete();
      exp_beat.delete();
      tick();
      tick();
      sys_rst_n = 1'b1;
      m_ready   = 1'b1;
      activity  = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (cmd_valid || frame_err || m_valid || overrun || busy) activity++;
      end
      checkOutput("post_reset_quiet", 32'(activity), 32'd0);

      checkOutput("leftover_expectations", 32'(exp_cmd.size() + exp_err.size() + exp_beat.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
